// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared types and helpers for the IF/MEM unified-memory arbiter.
package ama_riscv_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_own_t;

    localparam int BURST_CNT_W = 4;

    // Count consecutive data grants taken while fetch is waiting; any other grant restarts the count.
    function automatic logic [BURST_CNT_W-1:0] burst_next(
        input logic [BURST_CNT_W-1:0] cnt,
        input logic [BURST_CNT_W-1:0] limit,
        input logic                   d_grant,
        input logic                   if_waiting
    );
        if (d_grant && if_waiting) begin
            burst_next = (cnt >= limit) ? limit : cnt + 1'b1;
        end else begin
            burst_next = '0;
        end
    endfunction

endpackage

// File: rtl/ama_riscv_mem_arb.sv
// Shares one single-ported memory between instruction fetch and the load/store path.
// Data wins arbitration unless fetch has waited through a full data burst.
module ama_riscv_mem_arb
    import ama_riscv_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    output logic              if_stall,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_stall,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_D_BURST);

    arb_state_t             state;
    arb_own_t               own;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   pick_if;
    logic                   pick_d;
    logic                   wr_done;
    logic                   rd_done;

    // Arbitration only happens in IDLE; fetch overrides data once the burst limit is reached.
    always_comb begin
        pick_if = 1'b0;
        pick_d  = 1'b0;
        if (state == ST_IDLE) begin
            if (if_req && (!d_req || (burst_cnt == BURST_LIMIT))) begin
                pick_if = 1'b1;
            end else if (d_req) begin
                pick_d = 1'b1;
            end
        end
    end

    // Completion events: a store finishes on its grant, a load on its read data.
    assign wr_done  = (state == ST_ISSUE) && mem_gnt && mem_we;
    assign rd_done  = (state == ST_WAIT_R) && mem_rvalid;

    assign if_done  = rd_done && (own == OWN_IF);
    assign d_done   = wr_done || (rd_done && (own == OWN_D));
    assign if_rdata = if_done ? mem_rdata : 32'h0;
    assign d_rdata  = (rd_done && (own == OWN_D)) ? mem_rdata : 32'h0;
    assign if_stall = if_req && !if_done;
    assign d_stall  = d_req && !d_done;

    // Transaction sequencer: capture winner's fields, hold them until grant, then await read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            own       <= OWN_NONE;
            burst_cnt <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_if || pick_d) begin
                        state     <= ST_ISSUE;
                        mem_req   <= 1'b1;
                        burst_cnt <= burst_next(burst_cnt, BURST_LIMIT, pick_d, if_req);
                        if (pick_d) begin
                            own       <= OWN_D;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wmask <= d_wmask;
                        end else begin
                            own       <= OWN_IF;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= ST_IDLE;
                            own   <= OWN_NONE;
                        end else begin
                            state <= ST_WAIT_R;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid) begin
                        state <= ST_IDLE;
                        own   <= OWN_NONE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    own     <= OWN_NONE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Self-checking bench for the IF/MEM memory arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ama_riscv_mem_arb;

    localparam int AW   = 14;
    localparam int MAXB = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [31:0]   if_rdata;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_wmask;
    logic          d_done;
    logic [31:0]   d_rdata;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    int checks   = 0;
    int failures = 0;

    ama_riscv_mem_arb #(.ADDR_W(AW), .MAX_D_BURST(MAXB)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .if_stall   (if_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wmask    (d_wmask),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .d_stall    (d_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; if_addr = 14'h155; d_req = 1'b1; d_we = 1'b1;
        d_addr = 14'h2AA; d_wdata = 32'hFFFF_FFFF; d_wmask = 4'hF;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        checks++; if (mem_addr !== 14'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
        checks++; if (mem_wmask !== 4'h0) begin failures++; $display("FAIL reset_mem_wmask got=%h want=0", mem_wmask); end
        checks++; if (if_done !== 1'b0 || d_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b want=00", if_done, d_done); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", if_rdata, d_rdata); end
        checks++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b%b want=11", if_stall, d_stall); end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        checks++; if (if_stall !== 1'b0 || d_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b%b want=00", if_stall, d_stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lone_fetch();
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 14'h010;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_c0_mem_req got=%b want=0", mem_req); end
        checks++; if (if_stall !== 1'b1) begin failures++; $display("FAIL fetch_c0_stall got=%b want=1", if_stall); end
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_c1_mem_req got=%b want=1", mem_req); end
        checks++; if (mem_addr !== 14'h010) begin failures++; $display("FAIL fetch_c1_addr got=%h want=010", mem_addr); end
        checks++; if (mem_we !== 1'b0 || mem_wmask !== 4'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL fetch_c1_fields we=%b wmask=%h wdata=%h want 0/0/0", mem_we, mem_wmask, mem_wdata); end
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL fetch_c1_done got=%b want=0", if_done); end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        #1;
        checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL fetch_c2_done got=%b want=1", if_done); end
        checks++; if (if_rdata !== 32'h0000_0013) begin failures++; $display("FAIL fetch_c2_rdata got=%h want=00000013", if_rdata); end
        checks++; if (d_done !== 1'b0 || d_rdata !== 32'h0) begin failures++; $display("FAIL fetch_c2_d_port done=%b rdata=%h want 0/0", d_done, d_rdata); end
        checks++; if (if_stall !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fetch_c2_stall_req stall=%b req=%b want 0/0", if_stall, mem_req); end
        if_req = 1'b0;
    endtask

    task automatic test_store();
        logic e_done;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e_done  = (i == 2);
            mem_gnt = e_done;
            #1;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL store_c%0d_req_we req=%b we=%b want 1/1", i + 1, mem_req, mem_we); end
            checks++; if (mem_addr !== 14'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'b0011) begin failures++; $display("FAIL store_c%0d_fields addr=%h wdata=%h wmask=%b want 100/deadbeef/0011", i + 1, mem_addr, mem_wdata, mem_wmask); end
            checks++; if (d_done !== e_done) begin failures++; $display("FAIL store_c%0d_done got=%b want=%b", i + 1, d_done, e_done); end
            checks++; if (d_stall !== !e_done) begin failures++; $display("FAIL store_c%0d_stall got=%b want=%b", i + 1, d_stall, !e_done); end
        end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        #1;
        checks++; if (mem_req !== 1'b0 || d_done !== 1'b0 || if_done !== 1'b0) begin failures++; $display("FAIL store_no_wait_r req=%b d_done=%b if_done=%b want 0/0/0", mem_req, d_done, if_done); end
    endtask

    task automatic test_contention();
        bit own_d[8];
        bit exp_d[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int ntx, ndd, nid, if_after, c;
        logic rv;
        ntx = 0; ndd = 0; nid = 0; if_after = -1; rv = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 14'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 14'h300;
        for (c = 0; c < 60 && (ndd + nid) < 6; c++) begin
            @(negedge clk);
            mem_rvalid = rv; mem_gnt = mem_req; rv = mem_req;
            mem_rdata  = 32'h0C0D_0000 + 32'(c);
            #1;
            if (mem_req) begin
                if (ntx < 8) own_d[ntx] = (mem_addr == 14'h300);
                ntx++;
            end
            if (d_done) ndd++;
            if (if_done) begin nid++; if_after = ndd; end
        end
        if_req = 1'b0; d_req = 1'b0;
        checks++; if ((ndd + nid) != 6) begin failures++; $display("FAIL contention_timeout dones=%0d want 6", ndd + nid); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (own_d[i] !== exp_d[i]) begin failures++; $display("FAIL contention_grant%0d is_d=%b want %b", i, own_d[i], exp_d[i]); end
        end
        checks++; if (if_after != 4) begin failures++; $display("FAIL contention_if_after d_dones=%0d want 4", if_after); end
        checks++; if (c != 17) begin failures++; $display("FAIL contention_rate cycles=%0d want 17", c); end
    endtask

    task automatic test_load_routing();
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 14'h020; d_req = 1'b1; d_we = 1'b0; d_addr = 14'h044;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h044) begin failures++; $display("FAIL route_d_first req=%b addr=%h want 1/044", mem_req, mem_addr); end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL route_d_data done=%b rdata=%h want 1/cafef00d", d_done, d_rdata); end
        checks++; if (if_done !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL route_if_quiet done=%b rdata=%h want 0/0", if_done, if_rdata); end
        checks++; if (if_stall !== 1'b1 || d_stall !== 1'b0) begin failures++; $display("FAIL route_stalls if=%b d=%b want 1/0", if_stall, d_stall); end
        d_req = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h020 || mem_we !== 1'b0) begin failures++; $display("FAIL route_if_next req=%b addr=%h we=%b want 1/020/0", mem_req, mem_addr, mem_we); end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0093;
        #1;
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h00A0_0093 || d_rdata !== 32'h0) begin failures++; $display("FAIL route_if_data done=%b rdata=%h d_rdata=%h want 1/00a00093/0", if_done, if_rdata, d_rdata); end
        if_req = 1'b0;
    endtask

    task automatic test_requester_drop();
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0AB;
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0AB) begin failures++; $display("FAIL drop_issue req=%b addr=%h want 1/0ab", mem_req, mem_addr); end
        d_req = 1'b0; d_addr = 14'h3FF; d_we = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0AB || mem_we !== 1'b0) begin failures++; $display("FAIL drop_hold req=%b addr=%h we=%b want 1/0ab/0", mem_req, mem_addr, mem_we); end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h1234_5678) begin failures++; $display("FAIL drop_done done=%b rdata=%h want 1/12345678", d_done, d_rdata); end
        checks++; if (d_stall !== 1'b0) begin failures++; $display("FAIL drop_stall got=%b want 0", d_stall); end
        d_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 14'h030;
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_issue_req got=%b want 1", mem_req); end
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 14'h0) begin failures++; $display("FAIL rstmid_issue_drop req=%b addr=%h want 0/0", mem_req, mem_addr); end
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; if_req = 1'b1; if_addr = 14'h038;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h038) begin failures++; $display("FAIL rstmid_refetch req=%b addr=%h want 1/038", mem_req, mem_addr); end
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        checks++; if (if_done !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_wait done=%b req=%b want 0/0", if_done, mem_req); end
        rst = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        checks++; if (if_done !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_in_reset done=%b rdata=%h want 0/0", if_done, if_rdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (if_done !== 1'b0 || d_done !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_stale if_done=%b d_done=%b req=%b want 0/0/0", if_done, d_done, mem_req); end
        @(negedge clk);
        mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 14'h03C;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h03C) begin failures++; $display("FAIL rstmid_next_req req=%b addr=%h want 1/03c", mem_req, mem_addr); end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
        #1;
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h0010_0093) begin failures++; $display("FAIL rstmid_next_done done=%b rdata=%h want 1/00100093", if_done, if_rdata); end
        if_req = 1'b0;
    endtask

    // Transaction-level model: one transaction at a time, owner chosen by the
    // priority/burst rule, completion driven by the bench's own memory responder.
    task automatic test_random();
        bit            busy, granted, idle_cyc, if_orph, d_orph, win_d;
        int            burst_m, own_m;
        logic          xwe, e_req, e_if, e_d, e_drd;
        logic [AW-1:0] xa;
        logic [31:0]   xwd;
        logic [3:0]    xwm;
        busy = 0; granted = 0; if_orph = 0; d_orph = 0; burst_m = 0; own_m = 0;
        xwe = 1'b0; xa = '0; xwd = '0; xwm = '0;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; if_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            idle_cyc = !busy;
            e_req = busy && !granted;
            e_if = 1'b0; e_d = 1'b0; e_drd = 1'b0;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (e_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    mem_gnt = 1'b1;
                    if (xwe) e_d = 1'b1;
                end else begin
                    mem_rvalid = ($urandom_range(3, 0) == 0);
                end
            end else if (busy) begin
                if ($urandom_range(1, 0) == 1) begin
                    mem_rvalid = 1'b1;
                    if (own_m == 1) e_if = 1'b1;
                    else begin e_d = 1'b1; e_drd = 1'b1; end
                end else begin
                    mem_gnt = ($urandom_range(3, 0) == 0);
                end
            end else begin
                mem_gnt    = ($urandom_range(3, 0) == 0);
                mem_rvalid = ($urandom_range(3, 0) == 0);
            end
            #1;
            checks++; if (mem_req !== e_req) begin failures++; $display("FAIL rnd_mem_req cyc=%0d got=%b want=%b", c, mem_req, e_req); end
            if (e_req) begin
                checks++; if (mem_we !== xwe || mem_addr !== xa || mem_wdata !== xwd || mem_wmask !== xwm) begin failures++; $display("FAIL rnd_fields cyc=%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", c, mem_we, mem_addr, mem_wdata, mem_wmask, xwe, xa, xwd, xwm); end
            end
            checks++; if (if_done !== e_if || d_done !== e_d) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b%b want=%b%b", c, if_done, d_done, e_if, e_d); end
            checks++; if (if_rdata !== (e_if ? mem_rdata : 32'h0) || d_rdata !== (e_drd ? mem_rdata : 32'h0)) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h bus=%h", c, if_rdata, d_rdata, mem_rdata); end
            checks++; if (if_stall !== (if_req && !e_if) || d_stall !== (d_req && !e_d)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b%b want=%b%b", c, if_stall, d_stall, if_req && !e_if, d_req && !e_d); end
            // advance the model
            if (e_req && mem_gnt) begin
                granted = 1;
                if (xwe) busy = 0;
            end
            if (e_if || e_drd) busy = 0;
            if (e_if) begin if_req = 1'b0; if_orph = 0; end
            if (e_d) begin d_req = 1'b0; d_orph = 0; end
            // requesters: new requests, occasional abandonment
            if (!if_req && !if_orph) begin
                if ($urandom_range(2, 0) == 0) begin if_req = 1'b1; if_addr = AW'($urandom); end
            end else if (if_req && $urandom_range(19, 0) == 0) begin
                if_req = 1'b0; if_addr = AW'($urandom);
                if (busy && own_m == 1) if_orph = 1;
            end
            if (!d_req && !d_orph) begin
                if ($urandom_range(2, 0) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom); d_addr = AW'($urandom);
                    d_wdata = $urandom; d_wmask = 4'($urandom);
                end
            end else if (d_req && $urandom_range(19, 0) == 0) begin
                d_req = 1'b0; d_addr = AW'($urandom); d_wdata = $urandom;
                if (busy && own_m == 2) d_orph = 1;
            end
            // arbitration at the edge closing an idle cycle
            if (idle_cyc && (if_req || d_req)) begin
                win_d = d_req && !(if_req && burst_m == MAXB);
                busy = 1; granted = 0;
                if (win_d) begin
                    own_m = 2; xwe = d_we; xa = d_addr; xwd = d_wdata; xwm = d_wmask;
                    burst_m = if_req ? ((burst_m < MAXB) ? burst_m + 1 : MAXB) : 0;
                end else begin
                    own_m = 1; xwe = 1'b0; xa = if_addr; xwd = '0; xwm = '0;
                    burst_m = 0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store();
        test_contention();
        test_load_routing();
        test_requester_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
